// File: rtl/seq_stream_gen.sv
// Shared integer-sequence engine: one of eight recurrences streamed as a fixed-length
// run over valid/ready, with sticky overflow and a wrap or saturate policy.
module seq_stream_gen #(
   parameter int WIDTH    = 8,
   parameter int NTERMS   = 16,
   parameter int SATURATE = 0,
   parameter int IDX_W    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       mode,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_value,
   output logic [IDX_W-1:0] out_index,
   output logic             overflow,
   output logic             busy,
   output logic             done
);

   localparam int WW = 2*WIDTH + 2;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NTERMS - 1);
   localparam logic [WIDTH-1:0] MAXV = '1;

   typedef enum logic {IDLE, RUN} state_t;
   state_t state, state_next;

   logic [2:0]       mode_q;
   logic [WIDTH-1:0] a1, a2, a3;
   logic [WIDTH:0]   cnt, cnt_inc;
   logic [WW-1:0]    w1, w2, w3, c1, c2, nxt_wide;
   logic [WIDTH-1:0] init_a1, init_a2, init_a3;
   logic             load, handshake, advance, finish, ovf_now;

   function automatic logic [WIDTH-1:0] limit(input logic [WW-1:0] wide, input logic clamp);
      return clamp ? MAXV : wide[WIDTH-1:0];
   endfunction

   assign out_valid = (state == RUN);
   assign busy      = (state == RUN);
   assign load      = (state == IDLE) && start;
   assign handshake = out_valid && out_ready;
   assign advance   = handshake && (out_index != LAST);
   assign finish    = handshake && (out_index == LAST);

   assign cnt_inc = cnt + (WIDTH+1)'(1);
   assign w1 = WW'(a1);
   assign w2 = WW'(a2);
   assign w3 = WW'(a3);
   assign c1 = WW'(cnt_inc);
   assign c2 = c1 + WW'(1);

   // a1 is the term on the output, a2/a3 the two before it; cnt is n+1 for term n
   always_comb begin
      nxt_wide = '0;
      case (mode_q)
         3'd0:    nxt_wide = c1 * c1;
         3'd1:    nxt_wide = w1 + (w1 << 1);
         3'd2:    nxt_wide = (c1 * c2) >> 1;
         3'd3:    nxt_wide = w1 + w2;
         3'd4:    nxt_wide = (w1 << 1) + w2;
         3'd5:    nxt_wide = (out_index == '0) ? WW'(1) : w1 + w2;
         3'd6:    nxt_wide = w2 + w3;
         default: nxt_wide = w1 * w1 - w1 + WW'(1);
      endcase
   end

   assign ovf_now = |nxt_wide[WW-1:WIDTH];

   // Seed values chosen so the first step of each recurrence yields term 1
   always_comb begin
      init_a1 = WIDTH'(1);
      init_a2 = '0;
      init_a3 = '0;
      case (mode)
         3'd4: begin
            init_a1 = '0;
            init_a2 = WIDTH'(1);
         end
         3'd5, 3'd7: init_a1 = WIDTH'(2);
         3'd6:       init_a3 = WIDTH'(1);
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start)  state_next = RUN;
         RUN:     if (finish) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_value <= '0;
         out_index <= '0;
         overflow  <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= finish;
         if (load) begin
            out_value <= init_a1;
            out_index <= '0;
            overflow  <= 1'b0;
         end else if (advance) begin
            out_value <= limit(nxt_wide, (SATURATE != 0) && (overflow || ovf_now));
            out_index <= out_index + IDX_W'(1);
            overflow  <= overflow || ovf_now;
         end
      end
   end

   // Recurrence state keeps running on the truncated value under either policy
   always_ff @(posedge clk) begin
      if (load) begin
         mode_q <= mode;
         a1     <= init_a1;
         a2     <= init_a2;
         a3     <= init_a3;
         cnt    <= (WIDTH+1)'(1);
      end else if (advance) begin
         a1  <= nxt_wide[WIDTH-1:0];
         a2  <= a1;
         a3  <= a2;
         cnt <= cnt_inc;
      end
   end

endmodule

// File: tb/tb_seq_stream_gen.sv
// Scoreboard bench for seq_stream_gen: wrap and saturate instances share stimulus,
// expected runs come from the closed-form/recurrence definitions of each sequence.
module tb_seq_stream_gen;

   localparam int NT   = 8;
   localparam longint MAXV = 255;

   logic       clk, reset, start, out_ready;
   logic [2:0] mode;
   logic       w_valid, w_ovf, w_busy, w_done;
   logic [7:0] w_value, w_index;
   logic       s_valid, s_ovf, s_busy, s_done;
   logic [7:0] s_value, s_index;

   typedef struct packed {
      logic [7:0] value;
      logic [7:0] index;
      logic       ovf;
   } exp_t;

   exp_t q_wrap[$], q_sat[$];
   exp_t ew, es;
   int   checks = 0, errors = 0;
   bit   final_ovf;

   seq_stream_gen #(.WIDTH(8), .NTERMS(NT), .SATURATE(0), .IDX_W(8)) u_wrap (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .out_ready(out_ready),
      .out_valid(w_valid), .out_value(w_value), .out_index(w_index),
      .overflow(w_ovf), .busy(w_busy), .done(w_done));

   seq_stream_gen #(.WIDTH(8), .NTERMS(NT), .SATURATE(1), .IDX_W(8)) u_sat (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .out_ready(out_ready),
      .out_valid(s_valid), .out_value(s_value), .out_index(s_index),
      .overflow(s_ovf), .busy(s_busy), .done(s_done));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Expected run from the sequence definitions; wrap keeps the low 8 bits of each term
   task automatic push_run(input int m);
      longint t[NT];
      longint wide;
      bit     ovf;
      exp_t   e;
      for (int sat = 0; sat < 2; sat++) begin
         ovf = 0;
         for (int n = 0; n < NT; n++) begin
            case (m)
               0: wide = (n+1) * (n+1);
               1: wide = (n == 0) ? 1 : 3 * t[n-1];
               2: wide = (n+1) * (n+2) / 2;
               3: wide = (n < 2) ? 1 : t[n-1] + t[n-2];
               4: wide = (n == 0) ? 0 : (n == 1) ? 1 : 2 * t[n-1] + t[n-2];
               5: wide = (n == 0) ? 2 : (n == 1) ? 1 : t[n-1] + t[n-2];
               6: wide = (n < 3) ? 1 : t[n-2] + t[n-3];
               default: wide = (n == 0) ? 2 : t[n-1] * (t[n-1] - 1) + 1;
            endcase
            if (n > 0 && wide > MAXV) ovf = 1;
            t[n] = wide % (MAXV + 1);
            e.value = 8'((sat != 0 && ovf) ? MAXV : t[n]);
            e.index = 8'(n);
            e.ovf   = ovf;
            if (sat != 0) q_sat.push_back(e);
            else          q_wrap.push_back(e);
         end
      end
      final_ovf = ovf;
   endtask

   always @(negedge clk) begin
      if (!reset && w_valid && out_ready) begin
         if (q_wrap.size() == 0) check("wrap_unexpected_term", 1, 0);
         else begin
            ew = q_wrap.pop_front();
            check("wrap_value", w_value, ew.value);
            check("wrap_index", w_index, ew.index);
            check("wrap_ovf", w_ovf, ew.ovf);
         end
      end
   end

   always @(negedge clk) begin
      if (!reset && s_valid && out_ready) begin
         if (q_sat.size() == 0) check("sat_unexpected_term", 1, 0);
         else begin
            es = q_sat.pop_front();
            check("sat_value", s_value, es.value);
            check("sat_index", s_index, es.index);
            check("sat_ovf", s_ovf, es.ovf);
         end
      end
   end

   function automatic logic ready_of(input int rp, input int k);
      if (rp == 0) return 1'b1;
      if (rp == 1) return (k % 3) == 0;
      return ($urandom % 4) != 0;
   endfunction

   task automatic check_idle_zero(input string tag);
      check({tag, "_valid"}, w_valid | s_valid, 0);
      check({tag, "_value"}, w_value | s_value, 0);
      check({tag, "_index"}, w_index | s_index, 0);
      check({tag, "_ovf"},   w_ovf | s_ovf, 0);
      check({tag, "_busy"},  w_busy | s_busy, 0);
      check({tag, "_done"},  w_done | s_done, 0);
   endtask

   // Called at posedge+1; returns at posedge+1 of the done cycle
   task automatic run_seq(input int m, input int rp);
      bit got = 0;
      int k = 0;
      start = 1'b1;
      mode  = 3'(m);
      out_ready = ready_of(rp, k);
      push_run(m);
      @(posedge clk); #1;
      start = 1'b0;
      check("start_valid", w_valid & s_valid, 1);
      check("start_busy", w_busy & s_busy, 1);
      check("start_ovf", w_ovf | s_ovf, 0);
      for (int c = 0; c < 200; c++) begin
         if (w_done) begin
            got = 1;
            break;
         end
         k++;
         out_ready = ready_of(rp, k);
         if (w_busy) begin
            start = 1'($urandom);
            mode  = 3'($urandom);
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      if (!got) check("done_timeout", 0, 1);
      else begin
         check("done_sat", s_done, 1);
         check("done_wrap_drained", q_wrap.size(), 0);
         check("done_sat_drained", q_sat.size(), 0);
         check("done_valid", w_valid | s_valid, 0);
         check("done_busy", w_busy | s_busy, 0);
         check("done_wrap_ovf", w_ovf, final_ovf);
         check("done_sat_ovf", s_ovf, final_ovf);
      end
   endtask

   task automatic reset_mid_run();
      bit hit = 0;
      start = 1'b1;
      mode  = 3'd5;
      out_ready = 1'b1;
      push_run(5);
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 0; c < 50; c++) begin
         if (w_index == 8'd3) begin
            hit = 1;
            break;
         end
         @(posedge clk); #1;
      end
      if (!hit) check("reach_index3_timeout", 0, 1);
      reset = 1'b1;
      out_ready = 1'b0;
      @(posedge clk); #1;
      q_wrap.delete();
      q_sat.delete();
      check_idle_zero("midreset");
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         check("midreset_no_done", w_done | s_done | w_busy, 0);
      end
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      mode  = 3'd0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_idle_zero("reset");
      reset = 1'b0;
      @(posedge clk); #1;

      run_seq(3, 0);
      @(posedge clk); #1;
      check("done_one_cycle", w_done | s_done, 0);
      run_seq(1, 0);
      run_seq(4, 1);
      run_seq(7, 2);
      run_seq(6, 2);
      @(posedge clk); #1;
      reset_mid_run();
      run_seq(0, 0);
      run_seq(2, 1);

      for (int r = 0; r < 24; r++) begin
         int gap;
         gap = $urandom % 3;
         for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
            if (g == 0) check("done_one_cycle", w_done | s_done, 0);
         end
         run_seq($urandom % 8, $urandom % 3);
      end
      @(posedge clk); #1;
      check("final_idle", w_busy | s_busy | w_done, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_stream_gen.md
Name: seq_stream_gen

Overview:
- Parametrised integer-sequence engine. Replaces the fixed 8-bit free-running per-sequence generators with one shared engine.
- The mode selects one of eight sequences: squares, powers of 3, triangular, Fibonacci, Pell, Lucas, Padovan, Sylvester.
- Terms go out on a valid/ready stream, in a run of fixed length started by a start pulse.
- Overflow is detected and flagged, with a selectable policy of wrap or saturate.

Parameters:
- WIDTH, 8: term width in bits. Legal range is 4..32.
- NTERMS, 16: terms per run. Must be at least 1.
- SATURATE, 0: overflow policy. 0 = wrap modulo 2^WIDTH. 1 = clamp to 2^WIDTH-1.
- IDX_W, 8: width of the index output. Must satisfy 2^IDX_W >= NTERMS.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  run request; sampled in IDLE only
- mode  in  3  sequence select; latched on an accepted start
- out_ready  in  1  consumer ready
- out_valid  out  1  out_value holds a valid term
- out_value  out  WIDTH  current term
- out_index  out  IDX_W  term number within the run, 0-based
- overflow  out  1  sticky; set when any term of the run exceeded 2^WIDTH-1
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse after the last term is accepted

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset values: out_valid=0, out_value=0, out_index=0, overflow=0, busy=0, done=0, FSM in IDLE.
- Reset applied mid-run aborts the run immediately. No done pulse is produced.
- FSM has two states, IDLE and RUN.
- IDLE:
  - start=1 at edge t causes: mode latched, sequence state loaded, term 0 presented.
  - Results at t+1: out_valid=1, out_index=0, busy=1, overflow=0, FSM in RUN.
- RUN:
  - start is ignored. mode changes are ignored; the latched mode is used.
  - Handshake is out_valid && out_ready at an edge.
  - On a handshake with out_index < NTERMS-1: the next term and out_index+1 appear at the following edge. Throughput is one term per cycle.
  - No handshake: out_value and out_index are held stable.
  - On a handshake with out_index = NTERMS-1: next edge gives out_valid=0, busy=0, done=1 for one cycle, FSM in IDLE.
  - overflow keeps its value when the run ends.
- Back-to-back runs: start is accepted in the cycle where done=1, since the FSM is already in IDLE.
- Sequences, terms 0,1,2,...:
  - 0 squares (n+1)^2: 1,4,9,16,...
  - 1 powers of 3: 1,3,9,27,...
  - 2 triangular (n+1)(n+2)/2: 1,3,6,10,...
  - 3 Fibonacci: 1,1,2,3,5,...
  - 4 Pell a=2a1+a2: 0,1,2,5,12,29,...
  - 5 Lucas: 2,1,3,4,7,...
  - 6 Padovan a=a2+a3: 1,1,1,2,2,3,4,5,7,...
  - 7 Sylvester a=a1*(a1-1)+1: 2,3,7,43,1807,...
- Arithmetic:
  - The next term is computed at 2*WIDTH+2 bits from the WIDTH-bit state registers. The multipliers are combinational.
  - Squares and triangular use an internal counter, WIDTH bits plus a carry.
- Overflow detection: the wide next-term result exceeds 2^WIDTH-1. overflow is set in the same cycle the offending term is presented.
- SATURATE=0:
  - State and output take the result truncated to WIDTH bits.
  - The wrapped recurrence continues from the truncated state.
- SATURATE=1:
  - From the first overflowing term onward, out_value = 2^WIDTH-1 for every remaining term of the run.
  - The run length is unchanged.
- overflow is never asserted for term 0.
- A run that wraps the internal counter completes normally.

Test Plan (WIDTH=8, NTERMS=8, SATURATE=0 unless noted):
- Fibonacci: start with mode=3, out_ready=1 constant → values 1,1,2,3,5,8,13,21 at index 0..7. done pulses one cycle after index 7. overflow=0.
- Powers of 3: start with mode=1 → 1,3,9,27,81,243,217,139. overflow rises at index 6 (729 mod 256 = 217) and stays high after done.
- Same as the powers-of-3 case with SATURATE=1 → 1,3,9,27,81,243,255,255. overflow=1 from index 6.
- Backpressure: mode=4 Pell; toggle out_ready 1,0,0,1,... → each term (0,1,2,5,12,29,70,169) is held stable while out_ready=0. No term is skipped or repeated.
- Runs and ignored inputs:
  - start with mode=7 → 2,3,7,43,15,...; overflow set at index 4.
  - Then start again in the done cycle with mode=6 → new run 1,1,1,2,2,3,4,5.
  - start and mode changes mid-run are ignored.
- Reset mid-run: assert reset during Lucas at index 3 → next cycle has all outputs 0, FSM in IDLE, no done pulse. A subsequent start with mode=0 gives 1,4,9,...,64.
